mem_arbiter: RTL and testbench

- Sits between the core's bus-facing ports and a single-port word memory.
- Serialises instruction-fetch and load/store requests onto one memory port with a registered command and a ready handshake.
- Returns read data to the requester with a one-cycle valid pulse.
- Drives the hold flag that stalls the pipeline while a load/store is outstanding.
- Load/store has priority over fetch; an in-flight access always runs to completion.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (fetch, load/store) arbiter onto one single-port word memory.
// Optional wait-state abort compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_valid_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic [DW-1:0] ls_rdata_o,
  output logic          ls_valid_o,
  output logic          hold_o,
  output logic          err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_t;

  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  state_t state, state_nxt;
  logic   ls_take, if_take, timeout, done;

  // A requester is ignored in the cycle of its own valid pulse.
  assign ls_take  = ls_req_i && !ls_valid_o;
  assign if_take  = if_req_i && !if_valid_o;
  assign hold_o   = (state == LS_BUSY) || ls_take;
  assign mem_en_o = (state != IDLE);
  assign done     = mem_ready_i || timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // A ready arriving on the last allowed cycle still completes normally.
  assign timeout = (state != IDLE) && !mem_ready_i && (wait_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= timeout;
      if (state == IDLE)
        wait_cnt <= '0;
      else if (!mem_ready_i)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    // NOTE: assign the default before any branch so no path leaves state_nxt
    // unassigned; otherwise synthesis infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ls_take)
          state_nxt = LS_BUSY;
        else if (if_take)
          state_nxt = IF_BUSY;
      end
      IF_BUSY, LS_BUSY: begin
        if (done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_valid_o  <= 1'b0;
      ls_valid_o  <= 1'b0;
      if_data_o   <= '0;
      ls_rdata_o  <= '0;
    end else begin
      state      <= state_nxt;
      if_valid_o <= 1'b0;
      ls_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ls_take) begin
            mem_we_o    <= ls_we_i;
            mem_addr_o  <= ls_addr_i & WORD_MASK;
            mem_wdata_o <= ls_wdata_i;
          end else if (if_take) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i & WORD_MASK;
          end
        end
        IF_BUSY: begin
          if (done) begin
            if_data_o  <= mem_ready_i ? mem_rdata_i : '0;
            if_valid_o <= 1'b1;
          end
        end
        LS_BUSY: begin
          if (done) begin
            ls_rdata_o <= (mem_ready_i && !mem_we_o) ? mem_rdata_i : '0;
            ls_valid_o <= 1'b1;
            mem_we_o   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;
  localparam int NW      = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, ls_req_i, ls_we_i, mem_ready_i;
  logic [AW-1:0] if_addr_i, ls_addr_i;
  logic [DW-1:0] ls_wdata_i, mem_rdata_i;
  logic [DW-1:0] if_data_o, ls_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_valid_o, ls_valid_o, hold_o, err_o, mem_en_o, mem_we_o;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_valid_o (if_valid_o),
    .ls_req_i   (ls_req_i),
    .ls_we_i    (ls_we_i),
    .ls_addr_i  (ls_addr_i),
    .ls_wdata_i (ls_wdata_i),
    .ls_rdata_o (ls_rdata_o),
    .ls_valid_o (ls_valid_o),
    .hold_o     (hold_o),
    .err_o      (err_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: who owns the memory port, the command it issued,
  // how long it has been stalled, and what the requesters should see.
  typedef enum {M_NONE, M_IF, M_LS} owner_t;
  typedef enum {R_ALWAYS, R_NEVER, R_WAIT, R_RAND} ready_t;

  logic [31:0] mem [NW];
  owner_t      owner;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  int          stalls;
  logic        e_if_valid, e_ls_valid, e_err;
  logic [31:0] e_if_data, e_ls_data;
  ready_t      rmode;
  int          ws;
  bit          rand_en;

  function automatic int widx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  task automatic model_reset();
    owner = M_NONE; m_we = 1'b0; m_addr = '0; m_wdata = '0; stalls = 0;
    e_if_valid = 1'b0; e_ls_valid = 1'b0; e_err = 1'b0;
    e_if_data = '0; e_ls_data = '0;
  endtask

  task automatic model_edge();
    logic        v_if, v_ls, v_err, give_up;
    logic [31:0] data;
    v_if = 1'b0; v_ls = 1'b0; v_err = 1'b0; give_up = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (owner == M_NONE) begin
      if (ls_req_i && !e_ls_valid) begin
        owner = M_LS; m_we = ls_we_i; m_addr = ls_addr_i; m_wdata = ls_wdata_i; stalls = 0;
      end else if (if_req_i && !e_if_valid) begin
        owner = M_IF; m_we = 1'b0; m_addr = if_addr_i; stalls = 0;
      end
    end else begin
      if (!mem_ready_i) begin
        stalls++;
`ifdef MEM_ARB_TIMEOUT_EN
        give_up = (stalls > TIMEOUT);
`endif
      end
      if (mem_ready_i || give_up) begin
        data = (mem_ready_i && !m_we) ? mem[widx(m_addr)] : 32'h0;
        if (mem_ready_i && m_we) mem[widx(m_addr)] = m_wdata;
        if (owner == M_IF) begin e_if_data = data; v_if = 1'b1; end
        else               begin e_ls_data = data; v_ls = 1'b1; end
        v_err = give_up;
        owner = M_NONE;
      end
    end
    e_if_valid = v_if; e_ls_valid = v_ls; e_err = v_err;
  endtask

  task automatic issue_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    ls_req_i = 1'b1; ls_we_i = we; ls_addr_i = addr; ls_wdata_i = wdata;
  endtask

  task automatic issue_if(input logic [31:0] addr);
    if_req_i = 1'b1; if_addr_i = addr;
  endtask

  task automatic drive_all();
    if (e_ls_valid) ls_req_i = 1'b0;
    if (e_if_valid) if_req_i = 1'b0;
    if (rand_en && !rst) begin
      if (!ls_req_i && $urandom_range(0, 2) == 0) issue_ls(1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!if_req_i && $urandom_range(0, 2) == 0) issue_if($urandom);
    end
    case (rmode)
      R_ALWAYS: mem_ready_i = 1'b1;
      R_NEVER:  mem_ready_i = 1'b0;
      R_WAIT:   mem_ready_i = (stalls >= ws);
      default:  mem_ready_i = ($urandom_range(0, 2) == 0);
    endcase
    mem_rdata_i = (owner != M_NONE && !m_we) ? mem[widx(m_addr)] : $urandom;
  endtask

  task automatic check_outputs();
    check("mem_en", 32'(mem_en_o), 32'(owner != M_NONE));
    check("mem_we", 32'(mem_we_o), 32'(owner == M_LS && m_we));
    if (owner != M_NONE) check("mem_addr", mem_addr_o, {m_addr[31:2], 2'b00});
    if (owner == M_LS && m_we) check("mem_wdata", mem_wdata_o, m_wdata);
    check("if_valid", 32'(if_valid_o), 32'(e_if_valid));
    check("ls_valid", 32'(ls_valid_o), 32'(e_ls_valid));
    check("err", 32'(err_o), 32'(e_err));
    check("if_data", if_data_o, e_if_data);
    check("ls_rdata", ls_rdata_o, e_ls_data);
    check("hold", 32'(hold_o), 32'((owner == M_LS) || (ls_req_i && !e_ls_valid)));
  endtask

  // One clock: model advances on the edge, stimulus follows, outputs are
  // compared on the falling edge.
  task automatic cyc1();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    drive_all();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int ls_c, if_c;
    bit seen;

    rst = 1'b1; if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    if_addr_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    rmode = R_ALWAYS; ws = 0; rand_en = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    model_reset();

    // Reset state
    cyc1(); cyc1();
    check("rst mem_addr", mem_addr_o, 32'h0);
    check("rst mem_wdata", mem_wdata_o, 32'h0);
    check("rst err", 32'(err_o), 32'h0);
    rst = 1'b0;
    cyc1(); cyc1();

    // Load, memory ready in the first busy cycle
    mem[1] = 32'h1234_5678;
    rmode  = R_ALWAYS;
    issue_ls(1'b0, 32'h0000_0106, 32'h0);
    #1 check("ld hold c0", 32'(hold_o), 32'h1);
    cyc1();
    check("ld addr c1", mem_addr_o, 32'h0000_0104);
    check("ld hold c1", 32'(hold_o), 32'h1);
    cyc1();
    check("ld valid c2", 32'(ls_valid_o), 32'h1);
    check("ld rdata c2", ls_rdata_o, 32'h1234_5678);
    check("ld hold c2", 32'(hold_o), 32'h0);
    cyc1(); cyc1();

    // Store with 3 wait states
    rmode = R_WAIT; ws = 3;
    issue_ls(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    for (int k = 1; k <= 4; k++) begin
      cyc1();
      check("st mem_en", 32'(mem_en_o), 32'h1);
      check("st mem_we", 32'(mem_we_o), 32'h1);
      check("st wdata", mem_wdata_o, 32'hCAFE_F00D);
    end
    cyc1();
    check("st valid", 32'(ls_valid_o), 32'h1);
    check("st rdata", ls_rdata_o, 32'h0);
    cyc1(); cyc1();

    // Simultaneous fetch and load: load first, fetch two cycles later
    rmode = R_ALWAYS;
    issue_ls(1'b0, 32'h0000_0010, 32'h0);
    issue_if(32'h0000_0200);
    ls_c = -1; if_c = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc1();
      if (ls_valid_o && ls_c < 0) ls_c = k;
      if (if_valid_o && if_c < 0) if_c = k;
    end
    check("both ls cycle", 32'(ls_c), 32'd2);
    check("both if cycle", 32'(if_c), 32'd4);

    // Load arriving while a fetch is in flight
    mem[17] = 32'hA5A5_0011;
    rmode = R_WAIT; ws = 2;
    issue_if(32'h0000_1238);
    cyc1();
    issue_ls(1'b0, 32'h0000_0044, 32'h0);
    #1 check("ifb hold", 32'(hold_o), 32'h1);
    check("ifb addr", mem_addr_o, 32'h0000_1238);
    ls_c = -1; if_c = -1;
    for (int k = 2; k <= 14; k++) begin
      cyc1();
      if (ls_valid_o && ls_c < 0) ls_c = k;
      if (if_valid_o && if_c < 0) if_c = k;
    end
    check("ifb if cycle", 32'(if_c), 32'd4);
    check("ifb ls cycle", 32'(ls_c), 32'd8);
    check("ifb ls rdata", ls_rdata_o, 32'hA5A5_0011);

    // Reset in the middle of a load
    rmode = R_NEVER;
    mem[32] = 32'h0BAD_CAFE;
    issue_ls(1'b0, 32'h0000_0080, 32'h0);
    cyc1(); cyc1();
    rst = 1'b1; ls_req_i = 1'b0;
    cyc1();
    check("rst mid mem_en", 32'(mem_en_o), 32'h0);
    check("rst mid hold", 32'(hold_o), 32'h0);
    check("rst mid ls_valid", 32'(ls_valid_o), 32'h0);
    rst = 1'b0;
    cyc1();
    check("rst no pulse", 32'(ls_valid_o), 32'h0);
    rmode = R_ALWAYS;
    issue_ls(1'b0, 32'h0000_0080, 32'h0);
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      cyc1();
      seen = ls_valid_o;
    end
    check("post rst load done", 32'(seen), 32'h1);
    check("post rst rdata", ls_rdata_o, 32'h0BAD_CAFE);
    cyc1(); cyc1();

    // Memory never ready
    rmode = R_NEVER;
    issue_ls(1'b0, 32'h0000_00C0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      cyc1();
`ifdef MEM_ARB_TIMEOUT_EN
      check("to valid", 32'(ls_valid_o), 32'(k == 17));
      check("to err", 32'(err_o), 32'(k == 17));
      if (k == 17) check("to rdata", ls_rdata_o, 32'h0);
`else
      check("stall hold", 32'(hold_o), 32'h1);
      check("stall no valid", 32'(ls_valid_o), 32'h0);
`endif
    end
    rst = 1'b1; ls_req_i = 1'b0; if_req_i = 1'b0;
    cyc1();
    rst = 1'b0;
    cyc1();

    // Randomized traffic against the model
    rmode = R_RAND; rand_en = 1'b1;
    repeat (3000) cyc1();
    rand_en = 1'b0; rmode = R_ALWAYS;
    repeat (40) cyc1();
    check("drain idle", 32'(mem_en_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
